// File: rtl/spi_sram_responder.sv
// spi_sram_responder
//   SPI mode-0 serial-SRAM responder. The 48-bit frame is an 8-bit opcode, a
//   24-bit byte address and a 16-bit data word, all MSB first. The SPI pins
//   are oversampled in the clk domain. The frame is backed by an internal
//   memory of 2**ADDR_W words, each 16 bits wide.
// Ports
//   clk, rst : system clock and asynchronous active-high reset
//   sck      : SPI clock from the controller (each phase lasts at least 4 clk)
//   css      : active-low chip select
//   mosi     : serial data from the controller
//   miso     : serial data to the controller (changes on sck fall)
//   busy     : high while a frame is open
//   wr_done  : one-clk pulse that marks a write committing to memory
//   rd_done  : one-clk pulse after the last read data bit
//   err_op   : one-clk pulse when an unsupported opcode is decoded
module spi_sram_responder #(
  parameter int unsigned ADDR_W   = 16,
  parameter logic [7:0]  OP_WRITE = 8'h02,
  parameter logic [7:0]  OP_READ  = 8'h03
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic css,
  input  logic mosi,
  output logic miso,
  output logic busy,
  output logic wr_done,
  output logic rd_done,
  output logic err_op
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WR,
    S_RD,
    S_DONE,
    S_IGNORE
  } state_t;

  // Input synchronisers and edge-detect history
  logic sck_s1_q, sck_s2_q, sck_d_q;
  logic css_s1_q, css_s2_q, css_d_q;
  logic mosi_s1_q, mosi_s2_q;

  // armed_q is set only after css has been seen high following reset. A css
  // that is already low when reset is released therefore cannot open a frame.
  logic armed_q, armed_d;

  state_t             state_q, state_d;
  logic [22:0]        sh_q, sh_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               is_rd_q, is_rd_d;
  logic [ADDR_W-1:0]  word_q, word_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [15:0]        tx_q, tx_d;
  logic [1:0]         fetch_q, fetch_d;
  logic               miso_q, miso_d;
  logic               rd_done_q, rd_done_d;
  logic               err_q, err_d;
  logic [15:0]        rd_data_q;

  logic [15:0] mem [0:(2**ADDR_W)-1];

  logic sck_rise, sck_fall, css_fall;

  assign sck_rise = sck_s2_q & ~sck_d_q;
  assign sck_fall = ~sck_s2_q & sck_d_q;
  assign css_fall = armed_q & css_d_q & ~css_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_d_q   <= 1'b0;
      css_s1_q  <= 1'b0;
      css_s2_q  <= 1'b0;
      css_d_q   <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sck_s1_q  <= sck;
      sck_s2_q  <= sck_s1_q;
      sck_d_q   <= sck_s2_q;
      css_s1_q  <= css;
      css_s2_q  <= css_s1_q;
      css_d_q   <= css_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q   <= 1'b0;
      state_q   <= S_IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      is_rd_q   <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      tx_q      <= '0;
      fetch_q   <= '0;
      miso_q    <= 1'b0;
      rd_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      is_rd_q   <= is_rd_d;
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      tx_q      <= tx_d;
      fetch_q   <= fetch_d;
      miso_q    <= miso_d;
      rd_done_q <= rd_done_d;
      err_q     <= err_d;
    end
  end

  // The memory is not reset. rd_data_q follows word_q one clk later, and the
  // read FSM copies it into the output shifter on the next clk.
  always_ff @(posedge clk) begin
    if (we_q) begin
      mem[word_q] <= wdata_q;
    end
    rd_data_q <= mem[word_q];
  end

  always_comb begin
    armed_d   = armed_q | css_s2_q;
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    is_rd_d   = is_rd_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    tx_d      = tx_q;
    fetch_d   = fetch_q;
    miso_d    = miso_q;
    rd_done_d = 1'b0;
    err_d     = 1'b0;

    // Deselect has priority over any sck edge in the same clk.
    if ((state_q != S_IDLE) && css_s2_q) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
      cnt_d   = '0;
      fetch_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          miso_d = 1'b0;
          if (css_fall) begin
            state_d = S_CMD;
            cnt_d   = '0;
            sh_d    = '0;
          end
        end

        S_CMD: begin
          if (sck_rise) begin
            sh_d  = {sh_q[21:0], mosi_s2_q};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              if (({sh_q[6:0], mosi_s2_q} == OP_WRITE) ||
                  ({sh_q[6:0], mosi_s2_q} == OP_READ)) begin
                state_d = S_ADDR;
                is_rd_d = ({sh_q[6:0], mosi_s2_q} == OP_READ);
              end else begin
                state_d = S_IGNORE;
                err_d   = 1'b1;
              end
            end
          end
        end

        S_ADDR: begin
          if (sck_rise) begin
            sh_d  = {sh_q[21:0], mosi_s2_q};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_d = '0;
              // Byte-address bit k sits in sh_q[k-1]. Address bit 0 is the
              // incoming mosi bit, and it is dropped.
              word_d = sh_q[ADDR_W-1:0];
              if (is_rd_q) begin
                state_d = S_RD;
                fetch_d = 2'd1;
              end else begin
                state_d = S_WR;
              end
            end
          end
        end

        S_WR: begin
          if (sck_rise) begin
            sh_d  = {sh_q[21:0], mosi_s2_q};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              cnt_d   = '0;
              wdata_d = {sh_q[14:0], mosi_s2_q};
              we_d    = 1'b1;
              state_d = S_DONE;
            end
          end
        end

        S_RD: begin
          if (fetch_q == 2'd1) begin
            fetch_d = 2'd2;
          end else if (fetch_q == 2'd2) begin
            tx_d    = rd_data_q;
            fetch_d = 2'd0;
          end
          if (sck_fall) begin
            miso_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
          end
          if (sck_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              cnt_d     = '0;
              rd_done_d = 1'b1;
              state_d   = S_DONE;
            end
          end
        end

        S_DONE: begin
          if (sck_fall) begin
            miso_d = 1'b0;
          end
        end

        S_IGNORE: begin
          miso_d = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  assign miso    = miso_q;
  assign busy    = armed_q & ~css_s2_q;
  assign wr_done = we_q;
  assign rd_done = rd_done_q;
  assign err_op  = err_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
module tb_spi_sram_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;
  logic css = 1'b1;
  logic mosi = 1'b0;
  logic miso, busy, wr_done, rd_done, err_op;

  int checks = 0;
  int errors = 0;

  // Scoreboard. The stimulus pushes expectations, and the monitor consumes
  // them when a DUT pulse appears.
  logic [15:0] exp_rd[$];
  int          exp_wr  = 0;
  int          exp_err = 0;
  logic [15:0] rx_word = '0;
  bit          miso_seen = 1'b0;

  localparam int HALF = 6;

  spi_sram_responder #(.ADDR_W(16), .OP_WRITE(8'h02), .OP_READ(8'h03)) dut (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .css     (css),
    .mosi    (mosi),
    .miso    (miso),
    .busy    (busy),
    .wr_done (wr_done),
    .rd_done (rd_done),
    .err_op  (err_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor process
  always @(negedge clk) begin
    if (rd_done) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_done: got unexpected pulse expected none");
      end else begin
        logic [15:0] e;
        e = exp_rd.pop_front();
        if (rx_word !== e) begin
          errors++;
          $display("FAIL read_word: got %h expected %h", rx_word, e);
        end
      end
    end
    if (wr_done) begin
      checks++;
      if (exp_wr == 0) begin
        errors++;
        $display("FAIL wr_done: got unexpected pulse expected none");
      end else begin
        exp_wr--;
      end
    end
    if (err_op) begin
      checks++;
      if (exp_err == 0) begin
        errors++;
        $display("FAIL err_op: got unexpected pulse expected none");
      end else begin
        exp_err--;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // v is left-aligned: frame bit 0 is v[55]. When stop_at >= 0 the frame is
  // cut before that bit. do_rst chooses whether the cut is a reset or a css
  // rise.
  task automatic spi_frame(input logic [55:0] v, input int n, input int stop_at,
                           input bit do_rst);
    miso_seen = 1'b0;
    rx_word   = '0;
    css = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) begin
        if (do_rst) begin
          rst = 1'b1;
          #1;
          check("rst_miso", {31'd0, miso}, 32'd0);
          check("rst_busy", {31'd0, busy}, 32'd0);
          wait_clk(3);
          rst = 1'b0;
          wait_clk(4);
          check("stale_css_busy", {31'd0, busy}, 32'd0);
        end else begin
          css = 1'b1;
          repeat (3) @(posedge clk);
          #1;
          check("abort_busy", {31'd0, busy}, 32'd0);
        end
        break;
      end
      mosi = v[55 - i];
      wait_clk(HALF);
      if (i >= 32) rx_word = {rx_word[14:0], miso};
      if (miso === 1'b1) miso_seen = 1'b1;
      if (i == 8) check("busy_in_frame", {31'd0, busy}, 32'd1);
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
    wait_clk(HALF);
    css  = 1'b1;
    mosi = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [15:0] d);
    exp_wr++;
    spi_frame({8'h02, a, d, 8'h00}, 48, -1, 1'b0);
  endtask

  task automatic do_read(input logic [23:0] a, input logic [15:0] d);
    exp_rd.push_back(d);
    spi_frame({8'h03, a, 16'h0000, 8'h00}, 48, -1, 1'b0);
  endtask

  task automatic outstanding(input string name);
    check({name, "_rd_pending"},  exp_rd.size(), 32'd0);
    check({name, "_wr_pending"},  exp_wr,        32'd0);
    check({name, "_err_pending"}, exp_err,       32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(3);
    check("reset_miso",    {31'd0, miso},    32'd0);
    check("reset_busy",    {31'd0, busy},    32'd0);
    check("reset_wr_done", {31'd0, wr_done}, 32'd0);
    check("reset_rd_done", {31'd0, rd_done}, 32'd0);
    check("reset_err_op",  {31'd0, err_op},  32'd0);
    rst = 1'b0;
    wait_clk(8);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Write, then read back
    do_write(24'h000010, 16'hBEEF);
    do_read(24'h000010, 16'hBEEF);
    outstanding("wr_rd");

    // Aliasing
    do_write(24'h01FFFE, 16'h1234);
    do_read(24'h01FFFE, 16'h1234);
    do_write(24'h020000, 16'h5A5A);
    do_read(24'h000000, 16'h5A5A);
    do_read(24'h000001, 16'h5A5A);
    outstanding("alias");

    // Aborted write after 10 data bits
    do_write(24'h000010, 16'h1111);
    spi_frame({8'h02, 24'h000010, 16'h2222, 8'h00}, 48, 42, 1'b0);
    do_read(24'h000010, 16'h1111);
    outstanding("abort");

    // Bad opcode
    exp_err++;
    spi_frame({8'h05, 24'h000010, 16'hFFFF, 8'h00}, 48, -1, 1'b0);
    check("badop_miso", {31'd0, miso_seen}, 32'd0);
    do_read(24'h000010, 16'h1111);
    outstanding("badop");

    // Reset during read data bit 6
    spi_frame({8'h03, 24'h000010, 16'h0000, 8'h00}, 48, 38, 1'b1);
    do_write(24'h000020, 16'hC0DE);
    do_read(24'h000020, 16'hC0DE);
    outstanding("rst_mid");

    // Overlong write frame
    exp_wr++;
    spi_frame({8'h02, 24'h000030, 16'hABCD, 8'hFF}, 56, -1, 1'b0);
    do_read(24'h000030, 16'hABCD);
    outstanding("overlong");

    wait_clk(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
